alu_result_serializer: RTL and testbench

- Downstream stage of the ALU. Captures one ALU transaction: operands a/b plus the 12 result buses c..n.
- Streams the captured results one beat per cycle over a valid/ready interface, then sends a trailing XOR-checksum beat.
- Feeds the scoreboard/monitor path so results no longer need 12 parallel 7-bit taps.

---
 rtl/alu_result_serializer.sv | 124 ++++++++++++
 tb/tb_alu_result_serializer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_serializer.sv
// Purpose: captures one ALU transaction and streams its results c..n, then an XOR checksum beat.
// Latency: first beat (idx 0) is valid the cycle after the capture handshake; one beat per cycle.
// Backpressure: a beat is held stable until out_ready; in_ready stays low for the whole frame.
module alu_result_serializer #(
    parameter int NUM_RES = 12,
    parameter int RES_W   = 7,
    parameter int OP_W    = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_a,
    input  logic [OP_W-1:0]          in_b,
    input  logic [NUM_RES*RES_W-1:0] in_res,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_data,
    output logic [3:0]               out_idx,
    output logic                     out_last,
    output logic [2*OP_W-1:0]        out_ops,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt
);

    typedef enum logic [1:0] {IDLE, SEND, CKSUM} state_t;

    state_t                state_q;
    logic [RES_W-1:0]      res_q [NUM_RES];
    logic [RES_W-1:0]      cksum_q;
    logic [RES_W-1:0]      cksum_d;
    logic                  in_ready_q;
    logic                  busy_q;
    logic                  out_valid_q;
    logic [RES_W-1:0]      out_data_q;
    logic [3:0]            out_idx_q;
    logic [3:0]            idx_nxt_d;
    logic                  out_last_q;
    logic [2*OP_W-1:0]     out_ops_q;
    logic [CNT_W-1:0]      frame_cnt_q;

    // Checksum of the incoming result buses, folded in at capture time.
    always_comb begin
        cksum_d = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            cksum_d = cksum_d ^ in_res[i*RES_W +: RES_W];
        end
    end

    assign idx_nxt_d = out_idx_q + 4'd1;

    // Frame FSM; every output is registered so the consumer sees glitch-free beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cksum_q     <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_ops_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_RES; i++) begin
                            res_q[i] <= in_res[i*RES_W +: RES_W];
                        end
                        cksum_q     <= cksum_d;
                        out_ops_q   <= {in_a, in_b};
                        // Beat 0 goes out straight from the input bus.
                        out_data_q  <= in_res[RES_W-1:0];
                        out_idx_q   <= '0;
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_idx_q == 4'(NUM_RES-1)) begin
                            out_idx_q  <= 4'(NUM_RES);
                            out_data_q <= cksum_q;
                            out_last_q <= 1'b1;
                            state_q    <= CKSUM;
                        end else begin
                            out_idx_q  <= idx_nxt_d;
                            out_data_q <= res_q[idx_nxt_d];
                        end
                    end
                end
                CKSUM: begin
                    if (out_ready) begin
                        frame_cnt_q <= frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        out_idx_q   <= '0;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_ops   = out_ops_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: scoreboard of expected beats, pushed at capture, popped on accept.
// Inputs driven and outputs sampled on the falling clock edge.
// Each task drives its own scenario and checks inline.
module tb_alu_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [83:0] in_res;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic [7:0]  out_ops;
    logic        busy;
    logic [7:0]  frame_cnt;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [7:0]  exp_cnt = '0;
    // entry = {ops[7:0], last, idx[3:0], data[6:0]}
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    alu_result_serializer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_res(in_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_ops(out_ops),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    function automatic void push_frame(logic [3:0] a, logic [3:0] b, logic [83:0] r);
        logic [6:0] x;
        x = '0;
        for (int i = 0; i < 12; i++) begin
            x = x ^ r[i*7 +: 7];
            exp_q.push_back({a, b, 1'b0, 4'(i), r[i*7 +: 7]});
        end
        exp_q.push_back({a, b, 1'b1, 4'd12, x});
    endfunction

    function automatic logic [83:0] rand_res();
        logic [83:0] r;
        for (int i = 0; i < 12; i++) r[i*7 +: 7] = 7'($urandom_range(0, 127));
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_res = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, busy, frame_cnt, out_data, out_idx, out_last, out_ops} !== {1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 4'd0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b vld=%b busy=%b cnt=%0d data=%h idx=%0d last=%b ops=%h want rdy=1 vld=0 busy=0 rest 0",
                     in_ready, out_valid, busy, frame_cnt, out_data, out_idx, out_last, out_ops);
        end
        // rst together with a capture request: reset must win
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd3; in_res = rand_res();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        n_vec++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_vs_capture got vld=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
        end
        @(negedge clk);
        n_vec++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_vs_capture_late got vld=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic();
        logic [83:0] r;
        logic [19:0] e;
        int cyc;
        for (int i = 0; i < 12; i++) r[i*7 +: 7] = 7'(i + 1);
        n_vec++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
        in_a = 4'd6; in_b = 4'd4; in_res = r; in_valid = 1'b1;
        push_frame(4'd6, 4'd4, r);
        @(negedge clk);
        // post-capture input changes must not affect the frame
        in_valid = 1'b0; in_a = 4'hF; in_b = 4'hF; in_res = '1;
        out_ready = 1'b1;
        n_vec++;
        if ({busy, in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL basic_busy got busy=%b rdy=%b want 1 0", busy, in_ready);
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            n_vec++;
            if (!out_valid) begin
                n_fail++; $display("FAIL basic_gap cycle %0d got out_valid=0 want 1", cyc);
            end else begin
                e = exp_q.pop_front();
                if ({out_ops, out_last, out_idx, out_data} !== e) begin
                    n_fail++;
                    $display("FAIL basic_beat got ops=%h last=%b idx=%0d data=%h want ops=%h last=%b idx=%0d data=%h",
                             out_ops, out_last, out_idx, out_data, e[19:12], e[11], e[10:7], e[6:0]);
                end
            end
            @(negedge clk); cyc++;
        end
        exp_cnt++;
        n_vec++;
        if (exp_q.size() != 0 || cyc != 13) begin
            n_fail++; $display("FAIL basic_beat_count got %0d cycles left=%0d want 13 cycles left=0", cyc, exp_q.size());
            exp_q.delete();
        end
        n_vec++;
        if ({in_ready, out_valid, busy, frame_cnt} !== {1'b1, 1'b0, 1'b0, exp_cnt}) begin
            n_fail++; $display("FAIL basic_end got rdy=%b vld=%b busy=%b cnt=%0d want 1 0 0 %0d",
                               in_ready, out_valid, busy, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [83:0] r;
        logic [19:0] e;
        logic [19:0] held;
        logic        stalled;
        int cyc;
        for (int i = 0; i < 12; i++) r[i*7 +: 7] = 7'(i + 1);
        in_a = 4'd6; in_b = 4'd4; in_res = r; in_valid = 1'b1;
        push_frame(4'd6, 4'd4, r);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0; stalled = 1'b0; held = '0;
        while (exp_q.size() > 0 && cyc < 80) begin
            out_ready = (cyc % 3 == 0);
            if (stalled) begin
                n_vec++;
                if ({out_valid, out_ops, out_last, out_idx, out_data} !== {1'b1, held}) begin
                    n_fail++; $display("FAIL bp_hold got vld=%b beat=%h want vld=1 beat=%h",
                                       out_valid, {out_ops, out_last, out_idx, out_data}, held);
                end
            end
            stalled = out_valid && !out_ready;
            held = {out_ops, out_last, out_idx, out_data};
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_vec++;
                if (held !== e) begin
                    n_fail++; $display("FAIL bp_beat got %h want %h", held, e);
                end
            end
            @(negedge clk); cyc++;
        end
        out_ready = 1'b1;
        exp_cnt++;
        n_vec++;
        if (exp_q.size() != 0 || frame_cnt !== exp_cnt || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_end got left=%0d cnt=%0d vld=%b want 0 %0d 0", exp_q.size(), frame_cnt, out_valid, exp_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [83:0] r2;
        logic [83:0] r3;
        logic [19:0] e;
        logic        cap;
        int cyc;
        r2 = '1;
        r3 = rand_res();
        in_a = 4'd8; in_b = 4'd5; in_res = r2; in_valid = 1'b1;
        push_frame(4'd8, 4'd5, r2);
        @(negedge clk);
        // second request arrives while busy and is held by upstream
        in_a = 4'd3; in_b = 4'd9; in_res = r3;
        push_frame(4'd3, 4'd9, r3);
        n_vec++;
        if ({in_ready, busy} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_busy_refuse got rdy=%b busy=%b want 0 1", in_ready, busy);
        end
        out_ready = 1'b1;
        cyc = 0; cap = 1'b0;
        while (exp_q.size() > 0 && cyc < 80) begin
            if (in_valid && in_ready) cap = 1'b1;
            if (out_valid) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({out_ops, out_last, out_idx, out_data} !== e) begin
                    n_fail++; $display("FAIL b2b_beat got %h want %h", {out_ops, out_last, out_idx, out_data}, e);
                end
                if (e[11] && e[19:12] == 8'h85) begin
                    n_vec++;
                    if (frame_cnt !== exp_cnt) begin
                        n_fail++; $display("FAIL b2b_cnt_mid got %0d want %0d", frame_cnt, exp_cnt);
                    end
                end
            end
            @(negedge clk); cyc++;
            if (cap) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 8'd2;
        n_vec++;
        if (exp_q.size() != 0 || frame_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL b2b_end got left=%0d cnt=%0d want 0 %0d", exp_q.size(), frame_cnt, exp_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [83:0] r;
        logic [19:0] e;
        int cyc;
        r = rand_res();
        in_a = 4'd2; in_b = 4'd7; in_res = r; in_valid = 1'b1;
        push_frame(4'd2, 4'd7, r);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && out_idx == 4'd5) && cyc < 20) begin
            if (out_valid) void'(exp_q.pop_front());
            @(negedge clk); cyc++;
        end
        n_vec++;
        if (cyc != 5) begin n_fail++; $display("FAIL mid_reach_idx5 got %0d cycles want 5", cyc); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = '0;
        n_vec++;
        if ({out_valid, busy, in_ready, frame_cnt, out_data, out_idx, out_last, out_ops} !== {1'b0, 1'b0, 1'b1, 8'd0, 7'd0, 4'd0, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL mid_reset got vld=%b busy=%b rdy=%b cnt=%0d data=%h idx=%0d last=%b ops=%h want 0 0 1 0 0 0 0 0",
                               out_valid, busy, in_ready, frame_cnt, out_data, out_idx, out_last, out_ops);
        end
        r = rand_res();
        in_a = 4'd1; in_b = 4'd14; in_res = r; in_valid = 1'b1;
        push_frame(4'd1, 4'd14, r);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            if (out_valid) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({out_ops, out_last, out_idx, out_data} !== e) begin
                    n_fail++; $display("FAIL mid_restart_beat got %h want %h", {out_ops, out_last, out_idx, out_data}, e);
                end
            end
            @(negedge clk); cyc++;
        end
        exp_cnt++;
        n_vec++;
        if (exp_q.size() != 0 || frame_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL mid_restart_end got left=%0d cnt=%0d want 0 %0d", exp_q.size(), frame_cnt, exp_cnt);
            exp_q.delete();
        end
    endtask

    task automatic test_wrap();
        logic [83:0] r;
        logic [19:0] e;
        logic [3:0]  a;
        logic [3:0]  b;
        int cyc;
        out_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            r = rand_res(); a = 4'($urandom); b = 4'($urandom);
            in_a = a; in_b = b; in_res = r; in_valid = 1'b1;
            push_frame(a, b, r);
            @(negedge clk);
            in_valid = 1'b0;
            cyc = 0;
            while (exp_q.size() > 0 && cyc < 40) begin
                if (out_valid) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if ({out_ops, out_last, out_idx, out_data} !== e) begin
                        n_fail++; $display("FAIL wrap_beat frame %0d got %h want %h", f, {out_ops, out_last, out_idx, out_data}, e);
                    end
                end
                @(negedge clk); cyc++;
            end
            exp_cnt++;
            n_vec++;
            if (exp_q.size() != 0 || frame_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL wrap_cnt frame %0d got cnt=%0d left=%0d want %0d 0", f, frame_cnt, exp_q.size(), exp_cnt);
                exp_q.delete();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
